// File: rtl/alu_cmd_driver.sv
// Command/response driver wrapped around a combinational ALU.
// It registers one command, waits one cycle, captures the ALU result, then holds the response until the consumer accepts it.
module alu_cmd_driver #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    // command side
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [15:0]      cmd_a,
    input  logic [15:0]      cmd_b,
    input  logic [4:0]       cmd_f,
    input  logic             cmd_cin,
    input  logic             cmd_chain,
    input  logic             carry_clr,
    // ALU side
    output logic [15:0]      alu_a,
    output logic [15:0]      alu_b,
    output logic [4:0]       alu_f,
    output logic             alu_cin,
    input  logic [15:0]      alu_result,
    input  logic [5:0]       alu_status,
    // response side
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [15:0]      rsp_result,
    output logic [5:0]       rsp_status,
    output logic             carry_q,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t state;

    // cmd_ready resets to 1 so the driver is able to accept a command as soon as reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cmd_ready  <= 1'b1;
            alu_a      <= 16'h0000;
            alu_b      <= 16'h0000;
            alu_f      <= 5'b00000;
            alu_cin    <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_result <= 16'h0000;
            rsp_status <= 6'b000000;
            op_count   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking (<=) assignments only.
            // Every register therefore samples the value it had before this edge.
            unique case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        alu_a     <= cmd_a;
                        alu_b     <= cmd_b;
                        alu_f     <= cmd_f;
                        alu_cin   <= cmd_chain ? carry_q : cmd_cin;
                        cmd_ready <= 1'b0;
                        state     <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_status <= alu_status;
                    rsp_valid  <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_valid && rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        op_count  <= op_count + CNT_ONE;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // The capture in EXEC takes priority over carry_clr on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q <= 1'b0;
        end else if (state == EXEC) begin
            carry_q <= alu_status[5];
        end else if (carry_clr) begin
            carry_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver: the stub ALU returns values set by the bench.
// A second instance built with CNT_W=4 shows the counter wrapping.
module tb_alu_cmd_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_cin, cmd_chain, carry_clr, rsp_ready;
    logic [15:0] cmd_a, cmd_b;
    logic [4:0]  cmd_f;
    logic [15:0] stub_res;
    logic [5:0]  stub_stat;

    logic        cmd_ready, alu_cin, rsp_valid, carry_q;
    logic [15:0] alu_a, alu_b, rsp_result;
    logic [4:0]  alu_f;
    logic [5:0]  rsp_status;
    logic [15:0] op_count;

    logic        cmd_ready4, alu_cin4, rsp_valid4, carry_q4;
    logic [15:0] alu_a4, alu_b4, rsp_result4;
    logic [4:0]  alu_f4;
    logic [5:0]  rsp_status4;
    logic [3:0]  op_count4;

    int checks = 0;
    int errors = 0;
    logic        exp_carry = 1'b0;
    logic [15:0] exp_count = 16'd0;

    always #5 clk = ~clk;

    alu_cmd_driver #(.CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_f(cmd_f), .cmd_cin(cmd_cin),
        .cmd_chain(cmd_chain), .carry_clr(carry_clr),
        .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_cin(alu_cin),
        .alu_result(stub_res), .alu_status(stub_stat),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_status(rsp_status),
        .carry_q(carry_q), .op_count(op_count)
    );

    alu_cmd_driver #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready4),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_f(cmd_f), .cmd_cin(cmd_cin),
        .cmd_chain(cmd_chain), .carry_clr(carry_clr),
        .alu_a(alu_a4), .alu_b(alu_b4), .alu_f(alu_f4), .alu_cin(alu_cin4),
        .alu_result(stub_res), .alu_status(stub_stat),
        .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result4), .rsp_status(rsp_status4),
        .carry_q(carry_q4), .op_count(op_count4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Offer one command and follow it through EXEC into RESP; returns in RESP, #1 after the capture edge.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [4:0] f,
                        input logic cin, input logic chain,
                        input logic [15:0] res, input logic [5:0] stat,
                        input logic exp_cin, input logic clr_acc, input logic clr_cap);
        int waited = 0;
        @(negedge clk);
        while (!cmd_ready && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        check("cmd_ready_before_accept", cmd_ready, 1);
        cmd_a = a; cmd_b = b; cmd_f = f; cmd_cin = cin; cmd_chain = chain;
        cmd_valid = 1'b1; carry_clr = clr_acc;
        stub_res = res; stub_stat = stat;
        @(posedge clk); #1;
        cmd_valid = 1'b0; carry_clr = clr_cap;
        if (clr_acc) exp_carry = 1'b0;
        check("alu_a", alu_a, a);
        check("alu_b", alu_b, b);
        check("alu_f", alu_f, f);
        check("alu_cin", alu_cin, exp_cin);
        check("exec_cmd_ready", cmd_ready, 0);
        check("exec_rsp_valid", rsp_valid, 0);
        check("exec_carry_q", carry_q, exp_carry);
        @(posedge clk); #1;
        carry_clr = 1'b0;
        exp_carry = stat[5];
        check("rsp_valid_after_2_edges", rsp_valid, 1);
        check("rsp_result", rsp_result, res);
        check("rsp_status", rsp_status, stat);
        check("carry_q_capture", carry_q, exp_carry);
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        exp_count = exp_count + 16'd1;
        check("hs_rsp_valid", rsp_valid, 0);
        check("hs_cmd_ready", cmd_ready, 1);
        check("hs_op_count", op_count, exp_count);
    endtask

    typedef struct {
        logic [15:0] a, b;
        logic [4:0]  f;
        logic        cin, chain;
        logic [15:0] res;
        logic [5:0]  stat;
        logic        exp_cin;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{16'hFFFF, 16'h0001, 5'h00, 1'b1, 1'b0, 16'h0000, 6'b110011, 1'b1};
        vecs[1] = '{16'h1234, 16'h0001, 5'h00, 1'b0, 1'b1, 16'h1236, 6'b000000, 1'b1};
        vecs[2] = '{16'h7FFF, 16'h0001, 5'h00, 1'b0, 1'b0, 16'h8000, 6'b001100, 1'b0};
        vecs[3] = '{16'h00FF, 16'hFF01, 5'h03, 1'b0, 1'b1, 16'h0000, 6'b100101, 1'b0};
        vecs[4] = '{16'hAAAA, 16'h5555, 5'h1F, 1'b0, 1'b1, 16'hFFFF, 6'b001010, 1'b1};

        cmd_valid = 0; cmd_cin = 0; cmd_chain = 0; carry_clr = 0; rsp_ready = 0;
        cmd_a = 0; cmd_b = 0; cmd_f = 0; stub_res = 0; stub_stat = 0;
        rst_n = 1'b0;
        #12;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_op_count", op_count, 0);
        check("rst_carry_q", carry_q, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_rsp_status", rsp_status, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("post_rst_cmd_ready", cmd_ready, 1);

        for (int i = 0; i < 5; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].f, vecs[i].cin, vecs[i].chain,
                 vecs[i].res, vecs[i].stat, vecs[i].exp_cin, 1'b0, 1'b0);
            handshake();
        end

        // Response held back for 5 cycles; a stray command must be ignored meanwhile.
        send(16'h7FFF, 16'h0001, 5'h00, 1'b0, 1'b0, 16'h8000, 6'b001100, 1'b0, 1'b0, 1'b0);
        cmd_a = 16'h5A5A; cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("hold_rsp_valid", rsp_valid, 1);
            check("hold_rsp_result", rsp_result, 16'h8000);
            check("hold_cmd_ready", cmd_ready, 0);
            check("hold_alu_a", alu_a, 16'h7FFF);
            check("hold_op_count", op_count, exp_count);
        end
        cmd_valid = 1'b0;
        handshake();
        check("hold_carry_q", carry_q, 0);

        // carry_clr on the capture edge loses; one cycle later it clears.
        send(16'h0001, 16'h0002, 5'h04, 1'b0, 1'b0, 16'h0003, 6'b100000, 1'b0, 1'b0, 1'b1);
        check("clr_on_capture_carry_q", carry_q, 1);
        carry_clr = 1'b1;
        @(posedge clk); #1;
        carry_clr = 1'b0;
        exp_carry = 1'b0;
        check("clr_next_cycle_carry_q", carry_q, 0);
        check("clr_rsp_valid_held", rsp_valid, 1);
        handshake();

        // Chain alongside carry_clr at accept uses the pre-clear carry.
        send(16'h0010, 16'h0020, 5'h02, 1'b0, 1'b0, 16'h0030, 6'b100000, 1'b0, 1'b0, 1'b0);
        handshake();
        send(16'h0100, 16'h0200, 5'h02, 1'b0, 1'b1, 16'h0301, 6'b000000, 1'b1, 1'b1, 1'b0);
        handshake();

        // Reset pulsed in RESP aborts the operation.
        send(16'h1111, 16'h2222, 5'h07, 1'b1, 1'b0, 16'h3333, 6'b111111, 1'b1, 1'b0, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        check("abort_rsp_valid", rsp_valid, 0);
        check("abort_cmd_ready", cmd_ready, 1);
        check("abort_alu_a", alu_a, 0);
        check("abort_alu_b", alu_b, 0);
        check("abort_alu_f", alu_f, 0);
        check("abort_alu_cin", alu_cin, 0);
        check("abort_rsp_result", rsp_result, 0);
        check("abort_rsp_status", rsp_status, 0);
        check("abort_carry_q", carry_q, 0);
        check("abort_op_count", op_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("abort_no_rsp", rsp_valid, 0);
        check("abort_no_count", op_count, 0);
        exp_count = 16'd0;
        exp_carry = 1'b0;

        // Opcode sweep, back-to-back.
        for (int f = 0; f < 32; f++) begin
            send(16'(f * 3), 16'(f + 1), 5'(f), 1'b0, 1'b0, 16'(f * 4 + 1), 6'(f), 1'b0, 1'b0, 1'b0);
            handshake();
            if (f == 15) check("cnt4_wrap_16", op_count4, 0);
            if (f == 16) check("cnt4_after_wrap", op_count4, 1);
        end
        check("sweep_op_count", op_count, 32);
        check("sweep_cnt4", op_count4, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
